// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and derived constants for the L1 I-cache refill controller.
// Optional next-line prefetch is enabled by defining ICACHE_NEXTLINE_PF_EN.
package icache_refill_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_WRITE,
        ST_HOLD
    } state_t;

    localparam int unsigned REFILL_CNT_W = 16;

    localparam int unsigned DEF_BLOCK_W = 256;
    localparam int unsigned DEF_BEAT_W  = 64;
    localparam int unsigned BEATS       = DEF_BLOCK_W / DEF_BEAT_W;
    localparam int unsigned LINE_OFF_W  = $clog2(DEF_BLOCK_W / 8);

    function automatic int unsigned calc_beats(input int unsigned block_w, input int unsigned beat_w);
        return block_w / beat_w;
    endfunction

    function automatic int unsigned calc_off_w(input int unsigned block_w);
        return $clog2(block_w / 8);
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Beat counter plus line register: beat k of a refill lands in line[k*BEAT_W +: BEAT_W].
module icache_line_assembler
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned BLOCK_W = 256,
    parameter int unsigned BEAT_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_beat_valid,
    input  logic [BEAT_W-1:0]  i_beat_data,
    output logic               o_last_beat,
    output logic [BLOCK_W-1:0] o_line
);

    localparam int unsigned NBEATS = calc_beats(BLOCK_W, BEAT_W);
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [BLOCK_W-1:0] r_line;

    assign o_last_beat = i_beat_valid && (r_cnt == LAST_IDX);
    assign o_line      = r_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_beat_valid) begin
            r_line[int'(r_cnt) * BEAT_W +: BEAT_W] <= i_beat_data;
            r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// L1 I-cache miss handler: one outstanding line refill over request/grant + beat interface.
// Define ICACHE_NEXTLINE_PF_EN to add a single next-line prefetch after each demand refill.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLOCK_W = 256,
    parameter int unsigned BEAT_W  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    miss_i,
    input  logic [ADDR_W-1:0]       missAddr_i,
    input  logic                    flush_i,
    output logic                    memReq_o,
    output logic [ADDR_W-1:0]       memAddr_o,
    input  logic                    memGnt_i,
    input  logic                    memRdValid_i,
    input  logic [BEAT_W-1:0]       memRdData_i,
    output logic                    wrEnable_o,
    output logic [ADDR_W-1:0]       wrAddr_o,
    output logic [BLOCK_W-1:0]      instBlock_o,
    output logic                    busy_o,
    output logic [REFILL_CNT_W-1:0] refillCount_o
);

    localparam int unsigned OFF_W = calc_off_w(BLOCK_W);
    localparam logic [ADDR_W-1:0] LINE_MASK  = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(BLOCK_W / 8);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_mem_req;
    logic                    r_wr_en;
    logic                    r_busy;
    logic [REFILL_CNT_W-1:0] r_refill_cnt;
    logic                    w_capture;
    logic                    w_beat_valid;
    logic                    w_last_beat;
    logic [BLOCK_W-1:0]      w_line;
`ifdef ICACHE_NEXTLINE_PF_EN
    logic                    r_pf_armed;
    logic                    r_is_pf;
    logic                    w_pf_launch;
`endif

    assign w_capture    = (r_state == ST_IDLE) && miss_i;
    assign w_beat_valid = (r_state == ST_DATA) && memRdValid_i;

    icache_line_assembler #(
        .BLOCK_W (BLOCK_W),
        .BEAT_W  (BEAT_W)
    ) u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_capture),
        .i_beat_valid (w_beat_valid),
        .i_beat_data  (memRdData_i),
        .o_last_beat  (w_last_beat),
        .o_line       (w_line)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
`ifdef ICACHE_NEXTLINE_PF_EN
        w_pf_launch = 1'b0;
`endif
        case (r_state)
            ST_IDLE:  if (miss_i) w_next = ST_REQ;
            ST_REQ: begin
                if (memGnt_i) begin
                    w_next = ST_DATA;
`ifdef ICACHE_NEXTLINE_PF_EN
                end else if (flush_i && !r_is_pf) begin
`else
                end else if (flush_i) begin
`endif
                    w_next = ST_IDLE;
                end
            end
            ST_DATA:  if (w_last_beat) w_next = ST_WRITE;
            ST_WRITE: w_next = ST_HOLD;
            ST_HOLD: begin
`ifdef ICACHE_NEXTLINE_PF_EN
                if (r_pf_armed) begin
                    w_next      = ST_REQ;
                    w_pf_launch = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output strobes are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= '0;
            r_mem_req    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_refill_cnt <= '0;
`ifdef ICACHE_NEXTLINE_PF_EN
            r_pf_armed   <= 1'b0;
            r_is_pf      <= 1'b0;
`endif
        end else begin
            r_mem_req <= (w_next == ST_REQ);
            r_wr_en   <= (w_next == ST_WRITE);
            r_busy    <= (w_next != ST_IDLE);
            if (w_capture) r_addr <= missAddr_i & LINE_MASK;
            if ((r_state == ST_WRITE) && (r_refill_cnt != '1))
                r_refill_cnt <= r_refill_cnt + 1'b1;
`ifdef ICACHE_NEXTLINE_PF_EN
            if (w_capture) r_is_pf <= 1'b0;
            if ((r_state == ST_WRITE) && !r_is_pf) r_pf_armed <= 1'b1;
            if (w_pf_launch) begin
                r_addr     <= r_addr + LINE_BYTES;
                r_pf_armed <= 1'b0;
                r_is_pf    <= 1'b1;
            end
`endif
        end
    end

    assign memReq_o      = r_mem_req;
    assign memAddr_o     = r_addr;
    assign wrEnable_o    = r_wr_en;
    assign wrAddr_o      = r_addr;
    assign instBlock_o   = w_line;
    assign busy_o        = r_busy;
    assign refillCount_o = r_refill_cnt;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl; also covers ICACHE_NEXTLINE_PF_EN builds.
module tb_icache_refill_ctrl;

    logic         clk;
    logic         reset;
    logic         miss_i;
    logic [31:0]  missAddr_i;
    logic         flush_i;
    logic         memReq_o;
    logic [31:0]  memAddr_o;
    logic         memGnt_i;
    logic         memRdValid_i;
    logic [63:0]  memRdData_i;
    logic         wrEnable_o;
    logic [31:0]  wrAddr_o;
    logic [255:0] instBlock_o;
    logic         busy_o;
    logic [15:0]  refillCount_o;

    icache_refill_ctrl #(
        .ADDR_W  (32),
        .BLOCK_W (256),
        .BEAT_W  (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .miss_i        (miss_i),
        .missAddr_i    (missAddr_i),
        .flush_i       (flush_i),
        .memReq_o      (memReq_o),
        .memAddr_o     (memAddr_o),
        .memGnt_i      (memGnt_i),
        .memRdValid_i  (memRdValid_i),
        .memRdData_i   (memRdData_i),
        .wrEnable_o    (wrEnable_o),
        .wrAddr_o      (wrAddr_o),
        .instBlock_o   (instBlock_o),
        .busy_o        (busy_o),
        .refillCount_o (refillCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] line;
    } wr_t;

    logic [31:0]  req_q[$];
    wr_t          wr_q[$];
    int           checks = 0;
    int           passes = 0;
    int unsigned  exp_cnt = 0;
    logic [63:0]  bt [4];
    logic [63:0]  pbt [4];
    bit           done;

    task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        checks++;
        $display("FAIL %s: condition not reached within cycle budget (got timeout, expected event)", name);
    endtask

    // Reference line: beats land in ascending 64-bit lanes in arrival order.
    function automatic logic [255:0] build_line(input logic [63:0] b [4]);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Monitor: compares requests and line writes against the queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("reset_ctrl_outputs",
                     {memReq_o, wrEnable_o, busy_o, memAddr_o, wrAddr_o, refillCount_o}, '0);
            check_eq("reset_block", instBlock_o, '0);
            exp_cnt = 0;
        end else begin
            if (memReq_o) begin
                if (req_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_req: got request addr %h expected no request", memAddr_o);
                end else begin
                    check_eq("req_addr", memAddr_o, req_q[0]);
                    if (memGnt_i || flush_i) void'(req_q.pop_front());
                end
            end
            if (wrEnable_o) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got write addr %h expected no write", wrAddr_o);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check_eq("wr_addr", wrAddr_o, e.addr);
                    check_eq("wr_line", instBlock_o, e.line);
                    check_eq("wr_count_before", refillCount_o, exp_cnt);
                    if (exp_cnt < 32'hFFFF) exp_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beats(output logic [63:0] b [4]);
        for (int k = 0; k < 4; k++) b[k] = {$urandom(), $urandom()};
    endtask

    task automatic push_expect(input logic [31:0] line, input logic [63:0] b [4], input bit completes);
        wr_t e;
        req_q.push_back(line);
        if (completes) begin
            e.addr = line;
            e.line = build_line(b);
            wr_q.push_back(e);
        end
    endtask

    task automatic send_miss(input logic [31:0] addr, input bit fl);
        int t = 0;
        while (busy_o && t < 100) begin tick(); t++; end
        if (busy_o) note_timeout("idle_before_miss");
        miss_i     = 1'b1;
        missAddr_i = addr;
        flush_i    = fl;
        tick();
        miss_i     = 1'b0;
        flush_i    = 1'b0;
        missAddr_i = $urandom();
        check_eq("req_cycle_after_miss", memReq_o, 1'b1);
    endtask

    // mode: 0 normal, 1 flush in REQ, 2 flush in DATA, 3 reset after two beats
    task automatic serve(input logic [31:0] line, input logic [63:0] b [4], input int gnt_delay,
                         input int min_gap, input int max_gap, input int mode, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (!memReq_o && t < 30) begin tick(); t++; end
        if (!memReq_o) begin note_timeout("req_seen"); return; end
        for (int d = 0; d < gnt_delay; d++) begin
            memRdValid_i = ($urandom_range(0, 3) == 0);
            memRdData_i  = {$urandom(), $urandom()};
            tick();
            memRdValid_i = 1'b0;
            check_eq("req_held", memReq_o, 1'b1);
        end
        if (mode == 1) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            check_eq("flush_to_idle", {memReq_o, busy_o}, '0);
            ok = 1'b1;
            return;
        end
        memGnt_i = 1'b1;
        flush_i  = 1'($urandom_range(0, 1));
        tick();
        memGnt_i = 1'b0;
        flush_i  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int gap = $urandom_range(min_gap, max_gap);
            for (int g = 0; g < gap; g++) begin
                memRdData_i = {$urandom(), $urandom()};
                tick();
            end
            memRdValid_i = 1'b1;
            memRdData_i  = b[k];
            flush_i      = (mode == 2);
            tick();
            memRdValid_i = 1'b0;
            flush_i      = 1'b0;
            if (mode == 3 && k == 1) begin
                reset = 1'b0;
                tick();
                tick();
                reset = 1'b1;
                tick();
                memRdValid_i = 1'b1;
                memRdData_i  = {$urandom(), $urandom()};
                tick();
                memRdData_i  = {$urandom(), $urandom()};
                tick();
                memRdValid_i = 1'b0;
                tick();
                check_eq("stray_beats_idle", {busy_o, wrEnable_o, refillCount_o}, '0);
                ok = 1'b1;
                return;
            end
        end
        check_eq("write_after_last_beat", wrEnable_o, 1'b1);
        ok = 1'b1;
    endtask

    task automatic pf_follow(input logic [31:0] line);
`ifdef ICACHE_NEXTLINE_PF_EN
        bit ok;
        logic [63:0] pb [4];
        rand_beats(pb);
        push_expect(line + 32'd32, pb, 1'b1);
        serve(line + 32'd32, pb, $urandom_range(0, 3), 0, $urandom_range(0, 2), 0, ok);
`else
        check_eq("no_prefetch_req", {memReq_o, busy_o}, 2'b01);
        tick();
        tick();
        check_eq("idle_after_hold", {memReq_o, busy_o}, '0);
`endif
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        miss_i       = 1'b0;
        missAddr_i   = '0;
        flush_i      = 1'b0;
        memGnt_i     = 1'b0;
        memRdValid_i = 1'b0;
        memRdData_i  = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Directed: single miss, immediate grant, back-to-back beats.
        bt[0] = 64'h1111_1111_1111_1111;
        bt[1] = 64'h2222_2222_2222_2222;
        bt[2] = 64'h3333_3333_3333_3333;
        bt[3] = 64'h4444_4444_4444_4444;
        push_expect(32'h0000_1220, bt, 1'b1);
        send_miss(32'h0000_1234, 1'b0);
        check_eq("first_req_addr", memAddr_o, 32'h0000_1220);
        serve(32'h0000_1220, bt, 0, 0, 0, 0, done);
        check_eq("first_wr_addr", wrAddr_o, 32'h0000_1220);
        check_eq("first_line", instBlock_o,
                 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        tick();
        check_eq("first_count", refillCount_o, 16'd1);
        check_eq("one_cycle_write", wrEnable_o, 1'b0);
        pf_follow(32'h0000_1220);

        // Delayed grant and gapped beats.
        rand_beats(bt);
        push_expect(32'h00AB_CD40, bt, 1'b1);
        send_miss(32'h00AB_CD5C, 1'b0);
        serve(32'h00AB_CD40, bt, 5, 2, 2, 0, done);
        tick();
        pf_follow(32'h00AB_CD40);

        // Flush in REQ cancels; flush arriving with the miss is ignored in IDLE.
        rand_beats(bt);
        push_expect(32'h0000_8000, bt, 1'b0);
        send_miss(32'h0000_8004, 1'b1);
        serve(32'h0000_8000, bt, 2, 0, 1, 1, done);
        check_eq("count_after_flush", refillCount_o, exp_cnt);

        // Flush during DATA is ignored.
        rand_beats(bt);
        push_expect(32'h0000_9060, bt, 1'b1);
        send_miss(32'h0000_907F, 1'b0);
        serve(32'h0000_9060, bt, 1, 0, 1, 2, done);
        tick();
        pf_follow(32'h0000_9060);

        // Reset mid-DATA, then stray beats.
        rand_beats(bt);
        push_expect(32'h0001_0000, bt, 1'b0);
        send_miss(32'h0001_0010, 1'b0);
        serve(32'h0001_0000, bt, 1, 0, 0, 3, done);

`ifdef ICACHE_NEXTLINE_PF_EN
        // Wrap-around prefetch and a demand miss held during it.
        begin
            int t;
            rand_beats(bt);
            rand_beats(pbt);
            push_expect(32'hFFFF_FFE0, bt, 1'b1);
            push_expect(32'h0000_0000, pbt, 1'b1);
            send_miss(32'hFFFF_FFF8, 1'b0);
            serve(32'hFFFF_FFE0, bt, 0, 0, 1, 0, done);
            rand_beats(bt);
            push_expect(32'h0000_4000, bt, 1'b1);
            miss_i     = 1'b1;
            missAddr_i = 32'h0000_4010;
            serve(32'h0000_0000, pbt, 2, 0, 1, 0, done);
            t = 0;
            while (busy_o && t < 10) begin tick(); t++; end
            if (busy_o) note_timeout("idle_after_prefetch");
            tick();
            miss_i = 1'b0;
            check_eq("held_miss_req", memReq_o, 1'b1);
            serve(32'h0000_4000, bt, 1, 0, 1, 0, done);
            tick();
            pf_follow(32'h0000_4000);
        end
`endif

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            logic [31:0] ln;
            int m;
            int sel;
            bit comp;
            a   = $urandom();
            ln  = a & 32'hFFFF_FFE0;
            sel = $urandom_range(0, 9);
            m   = (sel <= 5) ? 0 : (sel <= 7) ? 1 : (sel == 8) ? 2 : 3;
            comp = (m == 0) || (m == 2);
            rand_beats(bt);
            push_expect(ln, bt, comp);
            send_miss(a, ($urandom_range(0, 3) == 0));
            serve(ln, bt, $urandom_range(0, 5), 0, $urandom_range(0, 2), m, done);
            if (comp) begin
                tick();
                pf_follow(ln);
            end
        end

        repeat (6) tick();
        check_eq("queues_drained", {req_q.size(), wr_q.size()}, '0);
        check_eq("final_count", refillCount_o, exp_cnt);
        check_eq("final_idle", {busy_o, memReq_o, wrEnable_o}, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the L1 instruction cache in fetch stage 1. It captures a cache miss and requests the aligned block from lower memory over a request/grant plus multi-beat read-data interface. It assembles the beats into one cache line and drives the cache's single-cycle write port (wrEnable/wrAddr/instBlock). It supports one outstanding refill, with an optional next-line prefetch.

## Interface
- ADDR_W, 32: address width; matches `SIZE_PC`.
- BLOCK_W, 256: cache line width in bits; matches `CACHE_WIDTH`.
- BEAT_W, 64: memory read-data beat width. BLOCK_W must be an integer multiple of BEAT_W; BEATS = BLOCK_W/BEAT_W.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- miss_i  in  1  L1 I-cache miss for the current PC (combinational from the cache).
- missAddr_i  in  ADDR_W  missing address; need not be line-aligned.
- flush_i  in  1  fetch redirect; the pending demand request is no longer needed.
- memReq_o  out  1  read request valid.
- memAddr_o  out  ADDR_W  line-aligned request address.
- memGnt_i  in  1  memory accepts the request in the cycle memReq_o=1 and memGnt_i=1.
- memRdValid_i  in  1  read-data beat valid.
- memRdData_i  in  BEAT_W  read-data beat.
- wrEnable_o  out  1  cache line write strobe.
- wrAddr_o  out  ADDR_W  line-aligned write address.
- instBlock_o  out  BLOCK_W  assembled line.
- busy_o  out  1  controller is not in IDLE.
- refillCount_o  out  16  number of completed line writes; saturates at 0xFFFF.

## Operation
- Line alignment: memAddr_o and wrAddr_o = address with the low log2(BLOCK_W/8) bits cleared.
- Beat placement: beat k (0-based, arrival order) goes to instBlock_o[k*BEAT_W +: BEAT_W]. Memory returns beats in ascending address order.
- State machine states: IDLE, REQ, DATA, WRITE, HOLD.
- IDLE:
  - miss_i=1 → latch the aligned address, clear the beat counter, go to REQ.
  - If miss_i and flush_i are asserted in the same cycle, the miss is still captured; flush only affects REQ.
- REQ:
  - Drive memReq_o=1 and memAddr_o = latched address.
  - memGnt_i=1 → go to DATA.
  - flush_i=1 with no grant in the same cycle → go to IDLE; no write occurs.
  - Grant and flush in the same cycle → the grant wins.
- DATA:
  - Each memRdValid_i=1 stores one beat and increments the counter.
  - After beat BEATS-1 is stored → go to WRITE.
  - flush_i is ignored; an accepted request always completes and is always written, because the data is valid.
- WRITE:
  - wrEnable_o=1 for exactly one cycle, with wrAddr_o and instBlock_o stable.
  - refillCount_o increments, saturating.
  - Next state is HOLD.
- HOLD: one dead cycle so the cache's miss output can settle on the refilled line; miss_i is ignored. Next state is IDLE, or REQ for a prefetch when configured (see Configuration).
- memRdValid_i outside DATA is ignored and does not corrupt state.
- Output reset values: memReq_o=0, memAddr_o=0, wrEnable_o=0, wrAddr_o=0, instBlock_o=0, busy_o=0, refillCount_o=0. State resets to IDLE and the beat counter to 0.
- Reset asserted mid-refill returns the block to IDLE immediately. Any beats still in flight after reset release are ignored.

## Timing
- miss_i is sampled at edge N → memReq_o=1 from cycle N+1.
- Best case, with grant at N+1 and beats at N+2..N+5 (BEATS=4):
  - wrEnable_o=1 at N+6.
  - HOLD at N+7.
  - IDLE at N+8; a new miss can be sampled at the N+8 edge.
- memReq_o and memAddr_o are held stable until granted.
- Every output is a registered state/datapath output; none is combinational from an input.

## Configuration
- ICACHE_NEXTLINE_PF_EN defined:
  - Each demand WRITE arms one prefetch of line address + BLOCK_W/8.
  - HOLD goes to REQ with that prefetch address and the same handshake. Prefetch REQ ignores flush_i.
  - The prefetch WRITE does not arm another prefetch.
  - A demand miss arriving during a prefetch waits; it is sampled in IDLE after the prefetch completes.
  - Address wrap at 2^ADDR_W is modulo.
- ICACHE_NEXTLINE_PF_EN undefined: HOLD always goes to IDLE, and no prefetch logic is present.

## Structure
- Shared package holds:
  - the state encoding enum (IDLE, REQ, DATA, WRITE, HOLD);
  - BEATS and the line-offset width as derived constants;
  - the refill-counter width.
- One sub-module, icache_line_assembler: beat counter plus BLOCK_W shift/insert register, with `last_beat` and `line` outputs. The FSM and handshakes stay in the top module.

## Test plan
- Single miss, missAddr_i=0x0000_1234, immediate grant, beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles → memAddr_o=0x0000_1220; wrEnable_o exactly one cycle with wrAddr_o=0x1220, instBlock_o={0x44..,0x33..,0x22..,0x11..}; refillCount_o=1.
- Grant delayed 5 cycles and beats with 2-cycle gaps → memReq_o held with a stable address; the write occurs one cycle after the 4th beat.
- flush_i during REQ before grant → back to IDLE, no wrEnable_o, refillCount_o unchanged. flush_i during DATA → refill completes and is written.
- reset pulled low mid-DATA after 2 beats → all outputs return to reset values; after release, 2 stray beats produce no write.
- With ICACHE_NEXTLINE_PF_EN, miss at 0xFFFF_FFE0 → demand write at 0xFFFF_FFE0, then prefetch request at 0x0000_0000; a demand miss asserted during the prefetch is issued only after the prefetch write.
